// File: rtl/udp_receiver_if.sv
// Avalon-ST receive stream from the MAC into the frame parser.
// Only the data/framing signals are used; the status side-band is carried but ignored.
interface udp_receiver_if;
  logic [31:0] rx_data;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_dval;
  logic [5:0]  rx_err;
  logic        rx_dsav;
  logic [17:0] rx_err_stat;
  logic [3:0]  rx_frm_type;
  logic [1:0]  rx_mod;
  logic        rx_a_full;
  logic        rx_a_empty;
  logic        rx_rdy;

  modport master (
    output rx_data, rx_sop, rx_eop, rx_dval, rx_err, rx_dsav, rx_err_stat,
           rx_frm_type, rx_mod, rx_a_full, rx_a_empty,
    input  rx_rdy
  );

  modport slave (
    input  rx_data, rx_sop, rx_eop, rx_dval, rx_err, rx_dsav, rx_err_stat,
           rx_frm_type, rx_mod, rx_a_full, rx_a_empty,
    output rx_rdy
  );
endinterface

// File: rtl/udp_receiver.sv
// Ethernet/IPv4 receive parser: classifies ARP request, ICMP echo and UDP-to-socket frames,
// realigns UDP payload into the packet buffer and latches reply fields for the transmitter.
module udp_receiver (
  input  logic        clk,
  input  logic        srstb,
  input  logic        rst,
  udp_receiver_if.slave rx,
  input  logic [31:0] ip_my,
  input  logic [15:0] socket_port,
  input  logic [15:0] adr,
  input  logic        rd,
  output logic [10:0] adr_rd,
  input  logic [31:0] data_from_mem,
  output logic [31:0] data,
  output logic [10:0] adr_wr,
  output logic [31:0] data_to_mem,
  output logic        wren_mem,
  output logic        SDRAM_WR,
  output logic        SDRAM_RD,
  output logic [31:0] data_mem2,
  output logic        int_rsv,
  output logic [15:0] size,
  output logic [15:0] length_packet_udp,
  output logic [15:0] adr_udp,
  output logic        send,
  output logic [7:0]  reply,
  output logic [47:0] source_mac,
  output logic [47:0] source_mac_ARP,
  output logic [31:0] ICMP_IP_DEST,
  output logic [7:0]  type_i,
  output logic [7:0]  code,
  output logic [15:0] identifier,
  output logic [15:0] seq_number,
  output logic [15:0] identification,
  output logic [31:0] crc_icmp,
  output logic [15:0] icmp_length,
  output logic [31:0] stat_err,
  output logic [31:0] test
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_FRAME = 2'd1, ST_FLUSH = 2'd2} state_t;

  // Echo reply checksum: type 8 -> 0 raises the one's-complement sum by 0800h.
  function automatic logic [15:0] icmp_reply_csum(input logic [15:0] csum);
    logic [16:0] sum;
    sum = {1'b0, csum} + 17'h00800;
    return sum[15:0] + {15'd0, sum[16]};
  endfunction

  state_t      state_r, state_nxt_s;
  logic [15:0] w_r, flush_k_r;
  logic [31:0] words_r [1:10];
  logic        rx_rdy_r;

  logic        beat_s, frame_beat_s, eop_s, abandon_s, err_s, long_s, ok_s;
  logic [15:0] idx_s, etype_s, udp_len_s, udp_sz_s, pay_k_s, n_done_s;
  logic [7:0]  proto_s;
  logic        ip_dst_ok_s, udp_hit_s, arp_hit_s, icmp_hit_s, pay_wr_s, pend_s;
  logic        acc_udp_s, acc_arp_s, acc_icmp_s, drop_s;
  logic        unused_s;

  assign beat_s       = rx.rx_dval;
  assign idx_s        = rx.rx_sop ? 16'd0 : w_r;
  assign frame_beat_s = beat_s & (rx.rx_sop | (state_r == ST_FRAME));
  assign eop_s        = frame_beat_s & rx.rx_eop;
  assign abandon_s    = beat_s & rx.rx_sop & (state_r == ST_FRAME);
  assign err_s        = (rx.rx_err != 6'd0);
  // Header words 1..10 are all captured once the frame reaches word 11.
  assign long_s       = (idx_s >= 16'd11);

  assign etype_s     = words_r[3][31:16];
  assign proto_s     = words_r[5][7:0];
  assign ip_dst_ok_s = ({words_r[7][15:0], words_r[8][31:16]} == ip_my);
  assign udp_hit_s   = (etype_s == 16'h0800) && (proto_s == 8'd17) && ip_dst_ok_s &&
                       (words_r[9][31:16] == socket_port);
  assign icmp_hit_s  = (etype_s == 16'h0800) && (proto_s == 8'd1) && ip_dst_ok_s &&
                       (words_r[8][15:8] == 8'h08);
  assign arp_hit_s   = (etype_s == 16'h0806) && (words_r[5][31:16] == 16'd1) &&
                       ({words_r[9][15:0], words_r[10][31:16]} == ip_my);

  assign udp_len_s = words_r[9][15:0];
  assign udp_sz_s  = (udp_len_s > 16'd8) ? ((udp_len_s - 16'd5) >> 2) : 16'd0;
  assign pay_k_s   = idx_s - 16'd11;
  assign pay_wr_s  = frame_beat_s & ~rx.rx_sop & long_s & udp_hit_s & (pay_k_s < udp_sz_s);
  assign n_done_s  = long_s ? (idx_s - 16'd10) : 16'd0;
  assign pend_s    = (n_done_s < udp_sz_s);

  assign ok_s       = eop_s & ~err_s & long_s;
  assign acc_udp_s  = ok_s & udp_hit_s;
  assign acc_arp_s  = ok_s & arp_hit_s;
  assign acc_icmp_s = ok_s & icmp_hit_s;
  assign drop_s     = abandon_s | (eop_s & ~err_s & ~(acc_udp_s | acc_arp_s | acc_icmp_s));

  assign adr_rd    = adr[10:0];
  assign SDRAM_WR  = wren_mem;
  assign rx.rx_rdy = rx_rdy_r;
  assign unused_s  = ^{adr[15:11], rx.rx_dsav, rx.rx_err_stat, rx.rx_frm_type, rx.rx_mod,
                       rx.rx_a_full, rx.rx_a_empty, words_r[1][31:16], words_r[3][15:0],
                       words_r[10][15:0]};

  // Frame state register.
  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb)   state_r <= ST_IDLE;
    else if (rst) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state: FLUSH covers the partial last payload word left behind by eop.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FRAME: begin
        if (eop_s) begin
          if (acc_udp_s && pend_s) state_nxt_s = ST_FLUSH;
          else                     state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_FRAME;
        end
      end
      ST_IDLE, ST_FLUSH: begin
        if (beat_s && rx.rx_sop && !rx.rx_eop) state_nxt_s = ST_FRAME;
        else                                   state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Word counting, header capture, payload writes, pulses and error statistics.
  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      w_r <= 16'd0;
      flush_k_r <= 16'd0;
      for (int i = 1; i <= 10; i++) words_r[i] <= 32'd0;
      data_mem2 <= 32'd0;
      test <= 32'd0;
      stat_err <= 32'd0;
      wren_mem <= 1'b0;
      adr_wr <= 11'd0;
      data_to_mem <= 32'd0;
      int_rsv <= 1'b0;
      send <= 1'b0;
    end else if (rst) begin
      w_r <= 16'd0;
      flush_k_r <= 16'd0;
      test <= 32'd0;
      stat_err <= 32'd0;
      wren_mem <= 1'b0;
      int_rsv <= 1'b0;
      send <= 1'b0;
    end else begin
      int_rsv <= acc_udp_s;
      send <= acc_arp_s | acc_icmp_s;
      wren_mem <= 1'b0;
      if (beat_s) begin
        data_mem2 <= rx.rx_data;
        test <= test + 32'd1;
      end
      if (frame_beat_s) begin
        if (idx_s != 16'hFFFF) w_r <= idx_s + 16'd1;
        for (int i = 1; i <= 10; i++) begin
          if (idx_s == 16'(i)) words_r[i] <= rx.rx_data;
        end
      end
      if (pay_wr_s) begin
        wren_mem <= 1'b1;
        adr_wr <= pay_k_s[10:0];
        data_to_mem <= {data_mem2[15:0], rx.rx_data[31:16]};
      end else if (state_r == ST_FLUSH) begin
        wren_mem <= 1'b1;
        adr_wr <= flush_k_r[10:0];
        data_to_mem <= {data_mem2[15:0], 16'h0000};
      end
      if (acc_udp_s) flush_k_r <= n_done_s;
      if (eop_s && err_s && (stat_err[15:0] != 16'hFFFF))
        stat_err[15:0] <= stat_err[15:0] + 16'd1;
      if (drop_s && (stat_err[31:16] != 16'hFFFF))
        stat_err[31:16] <= stat_err[31:16] + 16'd1;
    end
  end

  // Reply and datagram descriptors change only when a frame is accepted.
  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      size <= 16'd0; length_packet_udp <= 16'd0; adr_udp <= 16'd0;
      reply <= 8'd0; source_mac <= 48'd0; source_mac_ARP <= 48'd0;
      ICMP_IP_DEST <= 32'd0; type_i <= 8'd0; code <= 8'd0;
      identifier <= 16'd0; seq_number <= 16'd0; identification <= 16'd0;
      crc_icmp <= 32'd0; icmp_length <= 16'd0;
    end else begin
      if (acc_udp_s) begin
        size <= pend_s ? (n_done_s + 16'd1) : udp_sz_s;
        length_packet_udp <= udp_len_s;
        adr_udp <= words_r[8][15:0];
        source_mac <= {words_r[1][15:0], words_r[2]};
      end
      if (acc_arp_s) begin
        reply <= 8'h01;
        source_mac <= {words_r[1][15:0], words_r[2]};
        source_mac_ARP <= {words_r[5][15:0], words_r[6]};
        ICMP_IP_DEST <= words_r[7];
      end
      if (acc_icmp_s) begin
        reply <= 8'h02;
        source_mac <= {words_r[1][15:0], words_r[2]};
        ICMP_IP_DEST <= {words_r[6][15:0], words_r[7][31:16]};
        type_i <= words_r[8][15:8];
        code <= words_r[8][7:0];
        identifier <= words_r[9][15:0];
        seq_number <= words_r[10][31:16];
        identification <= words_r[4][15:0];
        crc_icmp <= {16'h0000, icmp_reply_csum(words_r[9][31:16])};
        icmp_length <= words_r[4][31:16] - 16'd20;
      end
    end
  end

  // Host read port and stream-ready flag.
  always_ff @(posedge clk or negedge srstb) begin
    if (!srstb) begin
      data <= 32'd0;
      SDRAM_RD <= 1'b0;
      rx_rdy_r <= 1'b0;
    end else begin
      if (rd) data <= data_from_mem;
      SDRAM_RD <= rd;
      rx_rdy_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_receiver.sv
// Directed bench for udp_receiver: UDP accept/reject, ARP, ICMP, abandoned and errored frames,
// soft clear and host read, with expected values built from the stimulus frames.
module tb_udp_receiver;
  logic        clk = 1'b0;
  logic        srstb, rst;
  logic [31:0] ip_my;
  logic [15:0] socket_port, adr;
  logic        rd;
  logic [10:0] adr_rd, adr_wr;
  logic [31:0] data_from_mem, data, data_to_mem, data_mem2;
  logic        wren_mem, SDRAM_WR, SDRAM_RD, int_rsv, send;
  logic [15:0] size, length_packet_udp, adr_udp, identifier, seq_number, identification, icmp_length;
  logic [7:0]  reply, type_i, code;
  logic [47:0] source_mac, source_mac_ARP;
  logic [31:0] ICMP_IP_DEST, crc_icmp, stat_err, test;

  udp_receiver_if rxif();

  udp_receiver dut (
    .clk(clk), .srstb(srstb), .rst(rst), .rx(rxif),
    .ip_my(ip_my), .socket_port(socket_port), .adr(adr), .rd(rd), .adr_rd(adr_rd),
    .data_from_mem(data_from_mem), .data(data), .adr_wr(adr_wr), .data_to_mem(data_to_mem),
    .wren_mem(wren_mem), .SDRAM_WR(SDRAM_WR), .SDRAM_RD(SDRAM_RD), .data_mem2(data_mem2),
    .int_rsv(int_rsv), .size(size), .length_packet_udp(length_packet_udp), .adr_udp(adr_udp),
    .send(send), .reply(reply), .source_mac(source_mac), .source_mac_ARP(source_mac_ARP),
    .ICMP_IP_DEST(ICMP_IP_DEST), .type_i(type_i), .code(code), .identifier(identifier),
    .seq_number(seq_number), .identification(identification), .crc_icmp(crc_icmp),
    .icmp_length(icmp_length), .stat_err(stat_err), .test(test)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] frm [0:31];

  // Write-port and pulse monitor, sampled away from the active edge.
  int          wr_n = 0, int_n = 0, send_n = 0;
  logic [10:0] wr_adr [0:127];
  logic [31:0] wr_dat [0:127];
  always @(negedge clk) begin
    if (wren_mem) begin
      if (wr_n < 128) begin
        wr_adr[wr_n] = adr_wr;
        wr_dat[wr_n] = data_to_mem;
      end
      wr_n = wr_n + 1;
    end
    if (int_rsv) int_n = int_n + 1;
    if (send) send_n = send_n + 1;
  end

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_udp(input logic [15:0] dport);
    frm[0]  = 32'h00AA_BBCC;
    frm[1]  = 32'hDDEE_0011;
    frm[2]  = 32'h2233_4455;
    frm[3]  = 32'h0800_4500;
    frm[4]  = {16'd98, 16'hABCD};
    frm[5]  = 32'h0000_4011;
    frm[6]  = 32'h0000_C0A8;
    frm[7]  = 32'h0001_0103;
    frm[8]  = 32'h033C_1F90;
    frm[9]  = {dport, 16'd78};
    frm[10] = 32'h0000_CAFE;
    for (int i = 11; i < 32; i++) frm[i] = {i[7:0], 8'hA5, i[7:0] + 8'h40, 8'h3C};
  endtask

  task automatic build_arp();
    for (int i = 0; i < 32; i++) frm[i] = 32'd0;
    frm[0]  = 32'hFFFF_FFFF;
    frm[1]  = 32'hFFFF_6677;
    frm[2]  = 32'h8899_AABB;
    frm[3]  = 32'h0806_0001;
    frm[4]  = 32'h0800_0604;
    frm[5]  = 32'h0001_0011;
    frm[6]  = 32'h2233_4455;
    frm[7]  = 32'hC0A8_0001;
    frm[9]  = 32'h0000_0103;
    frm[10] = 32'h033C_0000;
  endtask

  task automatic build_icmp();
    for (int i = 0; i < 32; i++) frm[i] = 32'd0;
    frm[0]  = 32'h00AA_BBCC;
    frm[1]  = 32'hDDEE_0011;
    frm[2]  = 32'h2233_4455;
    frm[3]  = 32'h0800_4500;
    frm[4]  = 32'h0054_4321;
    frm[5]  = 32'h0000_4001;
    frm[6]  = 32'h0000_C0A8;
    frm[7]  = 32'h0002_0103;
    frm[8]  = 32'h033C_0800;
    frm[9]  = 32'hF7FF_1234;
    frm[10] = 32'h0001_6162;
  endtask

  task automatic drive_frame(input int n, input logic [5:0] err, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxif.rx_data = frm[i];
      rxif.rx_dval = 1'b1;
      rxif.rx_sop  = (i == 0);
      rxif.rx_eop  = with_eop && (i == n - 1);
      rxif.rx_err  = (with_eop && (i == n - 1)) ? err : 6'd0;
    end
    @(negedge clk);
    rxif.rx_dval = 1'b0;
    rxif.rx_sop  = 1'b0;
    rxif.rx_eop  = 1'b0;
    rxif.rx_err  = 6'd0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  // Compare the 18 realigned payload writes of the 28-word UDP frame starting at monitor slot base.
  task automatic check_udp_writes(input int base);
    logic [31:0] exp_d;
    check_value("udp_wr_count", 64'(wr_n - base), 64'd18);
    for (int k = 0; k < 18; k++) begin
      if (11 + k < 28) exp_d = {frm[10 + k][15:0], frm[11 + k][31:16]};
      else             exp_d = {frm[10 + k][15:0], 16'h0000};
      check_value("udp_wr_adr", 64'(wr_adr[base + k]), 64'(k));
      check_value("udp_wr_dat", 64'(wr_dat[base + k]), 64'(exp_d));
    end
  endtask

  int base;

  initial begin
    srstb = 1'b0; rst = 1'b0;
    ip_my = 32'h0103_033C; socket_port = 16'd3002;
    adr = 16'd0; rd = 1'b0; data_from_mem = 32'd0;
    rxif.rx_data = 32'd0; rxif.rx_sop = 1'b0; rxif.rx_eop = 1'b0; rxif.rx_dval = 1'b0;
    rxif.rx_err = 6'd0; rxif.rx_dsav = 1'b0; rxif.rx_err_stat = 18'd0; rxif.rx_frm_type = 4'd0;
    rxif.rx_mod = 2'd0; rxif.rx_a_full = 1'b0; rxif.rx_a_empty = 1'b0;
    repeat (3) @(negedge clk);
    srstb = 1'b1;
    repeat (2) @(negedge clk);

    check_value("rst_rx_rdy", 64'(rxif.rx_rdy), 64'd1);
    check_value("rst_stat_err", 64'(stat_err), 64'd0);
    check_value("rst_wren", 64'(wren_mem), 64'd0);
    check_value("rst_int_rsv", 64'(int_rsv), 64'd0);
    check_value("rst_size", 64'(size), 64'd0);
    check_value("rst_test", 64'(test), 64'd0);

    // Accepted UDP datagram: 78-byte length -> 18 payload words, last one flushed.
    build_udp(16'h0BBA);
    base = wr_n; int_n = 0;
    drive_frame(28, 6'd0, 1'b1);
    settle();
    check_udp_writes(base);
    check_value("udp_int_rsv", 64'(int_n), 64'd1);
    check_value("udp_size", 64'(size), 64'd18);
    check_value("udp_len", 64'(length_packet_udp), 64'd78);
    check_value("udp_src_port", 64'(adr_udp), 64'h1F90);
    check_value("udp_src_mac", 64'(source_mac), 64'h0011_2233_4455);
    check_value("udp_stat_err", 64'(stat_err), 64'd0);
    check_value("udp_test_cnt", 64'(test), 64'd28);
    check_value("udp_sdram_wr", 64'(SDRAM_WR), 64'(wren_mem));

    // Wrong destination port: no writes, no interrupt, one drop, size held.
    build_udp(16'h0BBB);
    base = wr_n; int_n = 0;
    drive_frame(28, 6'd0, 1'b1);
    settle();
    check_value("port_wr_count", 64'(wr_n - base), 64'd0);
    check_value("port_int_rsv", 64'(int_n), 64'd0);
    check_value("port_stat_err", 64'(stat_err), 64'h0001_0000);
    check_value("port_size_held", 64'(size), 64'd18);

    // ARP request for our address.
    build_arp();
    send_n = 0;
    drive_frame(15, 6'd0, 1'b1);
    settle();
    check_value("arp_send", 64'(send_n), 64'd1);
    check_value("arp_reply", 64'(reply), 64'h01);
    check_value("arp_sha", 64'(source_mac_ARP), 64'h0011_2233_4455);
    check_value("arp_eth_src", 64'(source_mac), 64'h6677_8899_AABB);
    check_value("arp_spa", 64'(ICMP_IP_DEST), 64'hC0A8_0001);

    // ICMP echo request.
    build_icmp();
    send_n = 0;
    drive_frame(25, 6'd0, 1'b1);
    settle();
    check_value("icmp_send", 64'(send_n), 64'd1);
    check_value("icmp_reply", 64'(reply), 64'h02);
    check_value("icmp_crc", 64'(crc_icmp), 64'h0000_FFFF);
    check_value("icmp_ident", 64'(identifier), 64'h1234);
    check_value("icmp_seq", 64'(seq_number), 64'h0001);
    check_value("icmp_type", 64'(type_i), 64'h08);
    check_value("icmp_code", 64'(code), 64'h00);
    check_value("icmp_ip_id", 64'(identification), 64'h4321);
    check_value("icmp_len", 64'(icmp_length), 64'd64);
    check_value("icmp_src_ip", 64'(ICMP_IP_DEST), 64'hC0A8_0002);

    // Frame cut short by a new sop, then a complete frame.
    build_udp(16'h0BBA);
    base = wr_n; int_n = 0;
    drive_frame(10, 6'd0, 1'b0);
    drive_frame(28, 6'd0, 1'b1);
    settle();
    check_udp_writes(base);
    check_value("abort_int_rsv", 64'(int_n), 64'd1);
    check_value("abort_stat_err", 64'(stat_err), 64'h0002_0000);

    // MAC-flagged error on eop.
    int_n = 0;
    drive_frame(28, 6'd1, 1'b1);
    settle();
    check_value("err_int_rsv", 64'(int_n), 64'd0);
    check_value("err_stat_err", 64'(stat_err), 64'h0002_0001);

    // Soft clear.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check_value("srst_stat_err", 64'(stat_err), 64'd0);
    check_value("srst_test", 64'(test), 64'd0);

    // Host read: address passes through, data one cycle later.
    @(negedge clk);
    adr = 16'h0005; rd = 1'b1; data_from_mem = 32'hA5A5_A5A5;
    #1;
    check_value("rd_adr_rd", 64'(adr_rd), 64'h005);
    @(negedge clk);
    rd = 1'b0; data_from_mem = 32'h0;
    check_value("rd_data", 64'(data), 64'hA5A5_A5A5);
    check_value("rd_sdram_rd", 64'(SDRAM_RD), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
